// File: rtl/byte_ram_lsu_seq.sv
// byte_ram_lsu_seq: sequences 32-bit loads/stores onto a byte-wide RAM, one little-endian byte per cycle,
// then returns one response pulse carrying the extended load data or an alignment/size error.
module byte_ram_lsu_seq #(
    parameter int ADDR_W = 13
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_wren_o,
    output logic [7:0]        ram_wdata_o,
    input  logic [7:0]        ram_rdata_i
);
    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
    state_t r_state, w_next;
    logic [1:0] r_cnt, r_size, w_last_cnt;
    logic r_we, r_uns, r_err, w_accept, w_bad, w_sign;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0] r_wdata, r_res, w_ext;
    assign w_accept = req_valid_i && r_state == IDLE;
    assign w_bad = req_size_i == 2'b11 || (req_size_i == 2'b01 && req_addr_i[0]) ||
                   (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);
    assign w_last_cnt = r_size == 2'b10 ? 2'd3 : r_size == 2'b01 ? 2'd1 : 2'd0;
    // extension bit is the top byte actually transferred: bit 8N-1
    assign w_sign = !r_uns && (r_size == 2'b00 ? r_res[7] : r_size == 2'b01 ? r_res[15] : r_res[31]);
    assign w_ext = r_size == 2'b00 ? {{24{w_sign}}, r_res[7:0]} :
                   r_size == 2'b01 ? {{16{w_sign}}, r_res[15:0]} : r_res;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_next;
    end
    always_comb begin
        w_next = r_state == IDLE ? (w_accept ? (w_bad ? RESP : XFER) : IDLE) :
                 r_state == XFER ? (r_cnt == w_last_cnt ? RESP : XFER) : IDLE;
        req_ready_o = r_state == IDLE;
        ram_wren_o  = r_state == XFER && r_we;
        ram_addr_o  = r_state == XFER ? r_addr + ADDR_W'(r_cnt) : r_addr;
        ram_wdata_o = (r_state == XFER && r_we) ? r_wdata[{r_cnt, 3'b000} +: 8] : 8'h00;
        rsp_valid_o = r_state == RESP;
        rsp_err_o   = r_state == RESP && r_err;
        rsp_rdata_o = (r_state == RESP && !r_err && !r_we) ? w_ext : 32'h0;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr  <= '0;
            r_size  <= 2'b00;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_err   <= 1'b0;
            r_wdata <= 32'h0;
            r_res   <= 32'h0;
            r_cnt   <= 2'd0;
        end else if (w_accept) begin
            r_addr  <= req_addr_i;
            r_size  <= req_size_i;
            r_we    <= req_we_i;
            r_uns   <= req_unsigned_i;
            r_err   <= w_bad;
            r_wdata <= req_wdata_i;
            r_res   <= 32'h0;
            r_cnt   <= 2'd0;
        end else if (r_state == XFER) begin
            r_cnt <= r_cnt + 2'd1;
            if (!r_we) r_res[{r_cnt, 3'b000} +: 8] <= ram_rdata_i;
        end
    end
endmodule

// File: tb/tb_byte_ram_lsu_seq.sv
// tb_byte_ram_lsu_seq: directed vectors against byte_ram_lsu_seq with a behavioural 8192x8 RAM.
module tb_byte_ram_lsu_seq;
    localparam int AW = 13;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, req_ready, req_we = 1'b0, req_uns = 1'b0;
    logic [1:0] req_size = 2'b00;
    logic [AW-1:0] req_addr = '0;
    logic [31:0] req_wdata = 32'h0;
    logic rsp_valid, rsp_err, ram_wren;
    logic [31:0] rsp_rdata;
    logic [AW-1:0] ram_addr;
    logic [7:0] ram_wdata, ram_rdata;
    logic [7:0] mem [0:8191];
    int total = 0, bad = 0;
    logic [AW-1:0] wa [4];
    logic [7:0] wd [4];
    int nwr, lat;
    logic [31:0] rd, exp_w;
    logic er;
    int npulse;

    always #5 clk = ~clk;
    always @(posedge clk) if (ram_wren) mem[ram_addr] <= ram_wdata;
    assign ram_rdata = mem[ram_addr];

    byte_ram_lsu_seq #(.ADDR_W(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .ram_addr_o(ram_addr), .ram_wren_o(ram_wren),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one request; records write pulses and the response cycle (accept edge = cycle 0)
    task automatic run(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [AW-1:0] a, input logic [31:0] wdt);
        @(negedge clk);
        check("ready_before_req", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_uns = uns; req_addr = a; req_wdata = wdt;
        @(posedge clk);
        #1 req_valid = 1'b0; req_addr = ~a; req_wdata = ~wdt; req_we = ~we; req_uns = ~uns;
        nwr = 0; lat = 0; rd = 32'hx; er = 1'bx;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(negedge clk);
            if (ram_wren) begin
                if (nwr < 4) begin wa[nwr] = ram_addr; wd[nwr] = ram_wdata; end
                nwr++;
            end
            if (rsp_valid) begin lat = k; rd = rsp_rdata; er = rsp_err; end
        end
        if (lat == 0) check("rsp_timeout", 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_wren", ram_wren, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_wdata", ram_wdata, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(1'b1, 2'b10, 1'b0, 13'h0010, 32'hDEADBEEF);
        check("st_w_lat", lat, 5);
        check("st_w_err", er, 0);
        check("st_w_rdata", rd, 0);
        check("st_w_nwr", nwr, 4);
        exp_w = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            check("st_w_addr", wa[i], 13'h0010 + 13'(i));
            check("st_w_byte", wd[i], exp_w[8*i +: 8]);
        end

        run(1'b0, 2'b10, 1'b0, 13'h0010, 32'h0);
        check("ld_w_data", rd, 32'hDEADBEEF);
        check("ld_w_lat", lat, 5);
        check("ld_w_nwr", nwr, 0);
        run(1'b0, 2'b01, 1'b0, 13'h0012, 32'h0);
        check("ld_hs_data", rd, 32'hFFFFDEAD);
        check("ld_hs_lat", lat, 3);
        check("ld_hs_nwr", nwr, 0);
        run(1'b0, 2'b01, 1'b1, 13'h0010, 32'h0);
        check("ld_hu_data", rd, 32'h0000BEEF);
        run(1'b0, 2'b00, 1'b0, 13'h0013, 32'h0);
        check("ld_bs_data", rd, 32'hFFFFFFDE);
        check("ld_bs_lat", lat, 2);
        run(1'b0, 2'b00, 1'b1, 13'h0013, 32'h0);
        check("ld_bu_data", rd, 32'h000000DE);
        check("ld_bu_nwr", nwr, 0);

        run(1'b0, 2'b10, 1'b0, 13'h0011, 32'h0);
        check("err_mis_lat", lat, 1);
        check("err_mis_err", er, 1);
        check("err_mis_rdata", rd, 0);
        run(1'b1, 2'b11, 1'b0, 13'h0010, 32'hFFFFFFFF);
        check("err_sz_lat", lat, 1);
        check("err_sz_err", er, 1);
        check("err_sz_rdata", rd, 0);
        check("err_sz_nwr", nwr, 0);
        run(1'b1, 2'b01, 1'b0, 13'h0011, 32'h12345678);
        check("err_half_err", er, 1);
        check("err_half_nwr", nwr, 0);
        run(1'b0, 2'b10, 1'b0, 13'h0010, 32'h0);
        check("ram_unchanged", rd, 32'hDEADBEEF);
        check("ok_err_clear", er, 0);

        run(1'b1, 2'b10, 1'b0, 13'h1FFC, 32'h01020304);
        check("top_b0", mem[13'h1FFC], 8'h04);
        check("top_b1", mem[13'h1FFD], 8'h03);
        check("top_b2", mem[13'h1FFE], 8'h02);
        check("top_b3", mem[13'h1FFF], 8'h01);
        run(1'b0, 2'b10, 1'b0, 13'h1FFC, 32'h0);
        check("top_ld", rd, 32'h01020304);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_uns = 1'b0;
        req_addr = 13'h0020; req_wdata = 32'h000000AA;
        @(posedge clk);
        #1 req_addr = 13'h0021; req_wdata = 32'h000000BB;
        @(negedge clk);
        check("b2b_wren1", ram_wren, 1);
        check("b2b_addr1", ram_addr, 13'h0020);
        check("b2b_data1", ram_wdata, 8'hAA);
        @(negedge clk);
        check("b2b_rsp1", rsp_valid, 1);
        check("b2b_ready_in_rsp", req_ready, 0);
        @(negedge clk);
        check("b2b_ready2", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("b2b_wren2", ram_wren, 1);
        check("b2b_addr2", ram_addr, 13'h0021);
        check("b2b_data2", ram_wdata, 8'hBB);
        @(negedge clk);
        check("b2b_rsp2", rsp_valid, 1);
        check("b2b_mem20", mem[13'h0020], 8'hAA);
        check("b2b_mem21", mem[13'h0021], 8'hBB);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 13'h0040; req_wdata = 32'h11223344;
        @(posedge clk);
        #1 req_valid = 1'b0;
        npulse = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_wren2", ram_wren, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_wren_off", ram_wren, 0);
        check("rst_mid_ready", req_ready, 1);
        check("rst_mid_addr", ram_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid) npulse++;
        end
        check("rst_mid_no_rsp", npulse, 0);
        check("rst_mid_ready_after", req_ready, 1);
        check("rst_mid_m40", mem[13'h0040], 8'h44);
        check("rst_mid_m41", mem[13'h0041], 8'h33);
        check("rst_mid_m42", mem[13'h0042], 8'h00);
        check("rst_mid_m43", mem[13'h0043], 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/byte_ram_lsu_seq.md
Name: byte_ram_lsu_seq

Overview:
- Sequences 32-bit CPU load/store requests onto one 8-bit-wide data RAM (8192 x 8, synchronous write, asynchronous read).
- Splits each request into 1, 2 or 4 little-endian byte accesses, one per cycle.
- Assembles and extends load data, then returns a single-cycle response.
- Sits between the pipeline load/store stage and the byte RAM.

Parameters:
- ADDR_W, 13, byte address width; RAM depth is 2**ADDR_W.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid && ready at a rising edge
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  1 = zero-extend load, 0 = sign-extend load
- req_addr_i  in  ADDR_W  byte address
- req_wdata_i  in  32  store data, byte 0 = bits [7:0]
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors
- rsp_err_o  out  1  misaligned or illegal-size request
- ram_addr_o  out  ADDR_W  RAM byte address
- ram_wren_o  out  1  RAM write enable
- ram_wdata_o  out  8  RAM write byte
- ram_rdata_i  in  8  RAM read byte, combinational from ram_addr_o

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: state IDLE, byte counter 0, result register 0, all latched request fields 0. Outputs: req_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, ram_wren_o=0, ram_addr_o=0, ram_wdata_o=0.
- FSM states: IDLE, XFER, RESP.
- IDLE:
  - req_ready_o=1; all other handshake outputs 0.
  - On accept: latch addr, size, we, unsigned, wdata; clear result register and counter.
  - Byte count N = 1, 2 or 4 from req_size_i.
  - Error check: size 11, half with addr[0]=1, or word with addr[1:0]!=0 sets an error flag and goes to RESP. Otherwise go to XFER.
- XFER, cycle k = 0..N-1:
  - req_ready_o=0; ram_addr_o = base + k.
  - Alignment guarantees no wrap; the adder still wraps mod 2**ADDR_W.
  - Store: ram_wren_o=1, ram_wdata_o = wdata[8k+7:8k].
  - Load: ram_wren_o=0; ram_rdata_i captured into result[8k+7:8k] at the end of the cycle.
  - After k = N-1, go to RESP.
- Outside XFER: ram_wren_o=0, ram_wdata_o=0, ram_addr_o holds the latched base.
- RESP:
  - rsp_valid_o=1 for exactly one cycle; req_ready_o=0; next state IDLE.
  - Loads: rsp_rdata_o is the result extended from bit 8N-1 (sign or zero per unsigned flag).
  - Stores: rsp_rdata_o=0.
  - rsp_err_o = error flag; on error rsp_rdata_o=0 and the RAM is never written.
  - rsp_rdata_o and rsp_err_o are 0 whenever rsp_valid_o=0.
- Latency, accept edge = cycle 0:
  - Valid request: XFER in cycles 1..N, rsp_valid_o in cycle N+1, next accept possible at the end of cycle N+2.
  - Error: rsp_valid_o in cycle 1.
- Response has no backpressure. req_valid_i is ignored outside IDLE; inputs may change freely after accept.
- Reset asserted mid-XFER: abort immediately. Bytes already written stay in the RAM, no response is issued, and the block returns to the reset state.

Test Plan:
- Word store addr 0x0010, wdata 0xDEADBEEF -> ram_wren_o high 4 consecutive cycles with addr 0x10..0x13 and bytes EF,BE,AD,DE; rsp_valid_o in cycle 5; rsp_err_o=0; rsp_rdata_o=0.
- Word load 0x0010 after the store above -> rsp_rdata_o=0xDEADBEEF; half signed at 0x0012 -> 0xFFFFDEAD; byte signed at 0x0013 -> 0xFFFFFFDE; byte unsigned at 0x0013 -> 0x000000DE; no ram_wren_o pulses on any load.
- Word load at 0x0011 and request with size 11 -> rsp_err_o=1 in cycle 1; rsp_rdata_o=0; ram_wren_o never asserts; RAM contents unchanged.
- Word store at top address 0x1FFC, wdata 0x01020304 -> bytes 04,03,02,01 at 0x1FFC..0x1FFF; word load there returns 0x01020304.
- req_valid_i held high for two back-to-back byte stores (0x20 = 0xAA, then 0x21 = 0xBB) -> second accepted the cycle after the first rsp_valid_o; both bytes written.
- rst_ni pulled low during XFER cycle 3 of word store 0x11223344 to 0x0040 -> 0x40 = 0x44 and 0x41 = 0x33 written, 0x42..0x43 untouched, no rsp_valid_o, req_ready_o=1 once reset releases.
